// File: rtl/lnrv_icb_mux_pkg.sv
// -----------------------------------------------------------------------------
// lnrv_icb_mux_pkg
// Shared defaults and small helpers for the N-to-1 ICB mux.
// Optional feature macro used by the mux: LNRV_ICB_MUX_RR_EN
//   defined   -> round-robin arbitration
//   undefined -> fixed priority, lowest initiator index wins
// -----------------------------------------------------------------------------
package lnrv_icb_mux_pkg;

    localparam int unsigned ICB_ADDR_WIDTH_DEF = 32'd32;
    localparam int unsigned ICB_DATA_WIDTH_DEF = 32'd32;
    localparam int unsigned ICB_COUNT_DEF      = 32'd2;
    localparam int unsigned ICB_OTS_COUNT_DEF  = 32'd4;

    // Pointer width for a structure of 'depth' entries; never narrower than 1 bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 32'd1) ? $clog2(depth) : 32'd1;
    endfunction

    // Increment modulo 'modulus', used for FIFO pointers and the RR pointer.
    function automatic int unsigned wrap_inc(input int unsigned value,
                                             input int unsigned modulus);
        return ((value + 32'd1) >= modulus) ? 32'd0 : (value + 32'd1);
    endfunction

endpackage

// File: rtl/lnrv_icb_mux_ots_fifo.sv
// -----------------------------------------------------------------------------
// lnrv_icb_mux_ots_fifo
// In-order outstanding FIFO holding the initiator index of every command that
// has been accepted by the target and still awaits its response.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   push, din     write din when not full
//   pop           drop the head entry when not empty
//   full, empty   occupancy flags
//   head          entry at the read pointer (valid when !empty)
// -----------------------------------------------------------------------------
module lnrv_icb_mux_ots_fifo
    import lnrv_icb_mux_pkg::*;
#(
    parameter int P_WIDTH = 1,
    parameter int P_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               push,
    input  logic               pop,
    input  logic [P_WIDTH-1:0] din,
    output logic               full,
    output logic               empty,
    output logic [P_WIDTH-1:0] head
);

    localparam int PTR_W = int'(ptr_width(P_DEPTH));
    localparam int CNT_W = $clog2(P_DEPTH + 1);

    logic [P_WIDTH-1:0] mem_r [P_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               push_ok_s;
    logic               pop_ok_s;

    assign full      = (count_r == CNT_W'(P_DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign head      = mem_r[rd_ptr_r];
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < P_DEPTH; i++) begin
                mem_r[i] <= {P_WIDTH{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= PTR_W'(wrap_inc(32'(wr_ptr_r), P_DEPTH));
            end
            if (pop_ok_s) begin
                rd_ptr_r <= PTR_W'(wrap_inc(32'(rd_ptr_r), P_DEPTH));
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/lnrv_icb_mux.sv
// -----------------------------------------------------------------------------
// lnrv_icb_mux
// N-to-1 ICB arbiter/mux. Initiators share one ICB target; the granted index
// of every accepted command is queued so responses return in order to the
// initiator that issued them.
// Configuration macro: LNRV_ICB_MUX_RR_EN (round-robin when defined, fixed
// lowest-index priority otherwise).
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   mn_icb_cmd_*        packed per-initiator command channels (init 0 = LSBs)
//   mn_icb_rsp_*        packed per-initiator response channels
//   s_icb_cmd_*         muxed command channel to the target
//   s_icb_rsp_*         response channel from the target
// -----------------------------------------------------------------------------
module lnrv_icb_mux
    import lnrv_icb_mux_pkg::*;
#(
    parameter int P_ADDR_WIDTH = int'(ICB_ADDR_WIDTH_DEF),
    parameter int P_DATA_WIDTH = int'(ICB_DATA_WIDTH_DEF),
    parameter int P_ICB_COUNT  = int'(ICB_COUNT_DEF),
    parameter int P_OTS_COUNT  = int'(ICB_OTS_COUNT_DEF)
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic [P_ICB_COUNT-1:0]                  mn_icb_cmd_vld,
    output logic [P_ICB_COUNT-1:0]                  mn_icb_cmd_rdy,
    input  logic [P_ICB_COUNT-1:0]                  mn_icb_cmd_write,
    input  logic [P_ICB_COUNT*P_ADDR_WIDTH-1:0]     mn_icb_cmd_addr,
    input  logic [P_ICB_COUNT*P_DATA_WIDTH-1:0]     mn_icb_cmd_wdata,
    input  logic [P_ICB_COUNT*P_DATA_WIDTH/8-1:0]   mn_icb_cmd_wstrb,
    output logic [P_ICB_COUNT-1:0]                  mn_icb_rsp_vld,
    input  logic [P_ICB_COUNT-1:0]                  mn_icb_rsp_rdy,
    output logic [P_ICB_COUNT*P_DATA_WIDTH-1:0]     mn_icb_rsp_rdata,
    output logic [P_ICB_COUNT-1:0]                  mn_icb_rsp_err,
    output logic                                    s_icb_cmd_vld,
    input  logic                                    s_icb_cmd_rdy,
    output logic                                    s_icb_cmd_write,
    output logic [P_ADDR_WIDTH-1:0]                 s_icb_cmd_addr,
    output logic [P_DATA_WIDTH-1:0]                 s_icb_cmd_wdata,
    output logic [P_DATA_WIDTH/8-1:0]               s_icb_cmd_wstrb,
    input  logic                                    s_icb_rsp_vld,
    output logic                                    s_icb_rsp_rdy,
    input  logic [P_DATA_WIDTH-1:0]                 s_icb_rsp_rdata,
    input  logic                                    s_icb_rsp_err
);

    localparam int IDX_W  = $clog2(P_ICB_COUNT);
    localparam int STRB_W = P_DATA_WIDTH / 8;

    logic                    en_q_r;
    logic                    lock_r;
    logic [IDX_W-1:0]        lock_idx_r;
    logic [IDX_W-1:0]        arb_idx_s;
    logic                    arb_found_s;
    logic [IDX_W-1:0]        cand_idx_s;
    logic [IDX_W-1:0]        grant_idx_s;
    logic                    grant_vld_s;
    logic                    cmd_hsk_s;
    logic                    rsp_route_s;
    logic                    fifo_full_s;
    logic                    fifo_empty_s;
    logic [IDX_W-1:0]        fifo_head_s;

    logic [P_ADDR_WIDTH-1:0] addr_arr_s  [P_ICB_COUNT];
    logic [P_DATA_WIDTH-1:0] wdata_arr_s [P_ICB_COUNT];
    logic [STRB_W-1:0]       wstrb_arr_s [P_ICB_COUNT];

    for (genvar g = 0; g < P_ICB_COUNT; g++) begin : g_slice
        assign addr_arr_s[g]  = mn_icb_cmd_addr[g*P_ADDR_WIDTH +: P_ADDR_WIDTH];
        assign wdata_arr_s[g] = mn_icb_cmd_wdata[g*P_DATA_WIDTH +: P_DATA_WIDTH];
        assign wstrb_arr_s[g] = mn_icb_cmd_wstrb[g*STRB_W +: STRB_W];
    end

`ifdef LNRV_ICB_MUX_RR_EN
    logic [IDX_W-1:0] rr_ptr_r;
    logic [IDX_W:0]   cand_sum_s;

    // Round-robin search starting at the index after the last granted one.
    always_comb begin
        arb_found_s = 1'b0;
        arb_idx_s   = {IDX_W{1'b0}};
        cand_sum_s  = {(IDX_W+1){1'b0}};
        cand_idx_s  = {IDX_W{1'b0}};
        for (int k = 0; k < P_ICB_COUNT; k++) begin
            cand_sum_s = {1'b0, rr_ptr_r} + (IDX_W+1)'(k);
            if (cand_sum_s >= (IDX_W+1)'(P_ICB_COUNT)) begin
                cand_sum_s = cand_sum_s - (IDX_W+1)'(P_ICB_COUNT);
            end else begin
                cand_sum_s = cand_sum_s;
            end
            cand_idx_s = cand_sum_s[IDX_W-1:0];
            if (!arb_found_s && mn_icb_cmd_vld[cand_idx_s]) begin
                arb_found_s = 1'b1;
                arb_idx_s   = cand_idx_s;
            end else begin
                arb_found_s = arb_found_s;
            end
        end
    end

    // RR pointer holds the next search start; it moves only on a command handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_r <= {IDX_W{1'b0}};
        end else if (cmd_hsk_s) begin
            rr_ptr_r <= IDX_W'(wrap_inc(32'(grant_idx_s), P_ICB_COUNT));
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end
`else
    // Fixed priority: the lowest requesting index wins.
    always_comb begin
        arb_found_s = 1'b0;
        arb_idx_s   = {IDX_W{1'b0}};
        cand_idx_s  = {IDX_W{1'b0}};
        for (int k = 0; k < P_ICB_COUNT; k++) begin
            cand_idx_s = IDX_W'(k);
            if (!arb_found_s && mn_icb_cmd_vld[cand_idx_s]) begin
                arb_found_s = 1'b1;
                arb_idx_s   = cand_idx_s;
            end else begin
                arb_found_s = arb_found_s;
            end
        end
    end
`endif

    // Grant selection: a stalled command keeps its index so the target sees stable fields.
    always_comb begin
        if (lock_r) begin
            grant_idx_s = lock_idx_r;
            grant_vld_s = en_q_r & ~fifo_full_s & mn_icb_cmd_vld[lock_idx_r];
        end else begin
            grant_idx_s = arb_idx_s;
            grant_vld_s = en_q_r & ~fifo_full_s & arb_found_s;
        end
    end

    assign cmd_hsk_s     = grant_vld_s & s_icb_cmd_rdy;
    assign s_icb_cmd_vld = grant_vld_s;

    // Command field mux and per-initiator ready.
    always_comb begin
        mn_icb_cmd_rdy = {P_ICB_COUNT{1'b0}};
        if (grant_vld_s) begin
            s_icb_cmd_write = mn_icb_cmd_write[grant_idx_s];
            s_icb_cmd_addr  = addr_arr_s[grant_idx_s];
            s_icb_cmd_wdata = wdata_arr_s[grant_idx_s];
            s_icb_cmd_wstrb = wstrb_arr_s[grant_idx_s];
            mn_icb_cmd_rdy[grant_idx_s] = s_icb_cmd_rdy;
        end else begin
            s_icb_cmd_write = 1'b0;
            s_icb_cmd_addr  = {P_ADDR_WIDTH{1'b0}};
            s_icb_cmd_wdata = {P_DATA_WIDTH{1'b0}};
            s_icb_cmd_wstrb = {STRB_W{1'b0}};
        end
    end

    // Enable comes up one cycle after reset release; lock tracks a stalled command.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q_r     <= 1'b0;
            lock_r     <= 1'b0;
            lock_idx_r <= {IDX_W{1'b0}};
        end else begin
            en_q_r     <= 1'b1;
            lock_r     <= grant_vld_s & ~s_icb_cmd_rdy;
            lock_idx_r <= grant_idx_s;
        end
    end

    lnrv_icb_mux_ots_fifo #(
        .P_WIDTH (IDX_W),
        .P_DEPTH (P_OTS_COUNT)
    ) u_ots_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (cmd_hsk_s),
        .pop     (s_icb_rsp_vld & s_icb_rsp_rdy),
        .din     (grant_idx_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .head    (fifo_head_s)
    );

    // With nothing outstanding a target response is never forwarded nor accepted.
    assign rsp_route_s      = en_q_r & ~fifo_empty_s;
    assign s_icb_rsp_rdy    = rsp_route_s & mn_icb_rsp_rdy[fifo_head_s];
    assign mn_icb_rsp_rdata = {P_ICB_COUNT{s_icb_rsp_rdata}};
    assign mn_icb_rsp_err   = {P_ICB_COUNT{s_icb_rsp_err}};

    // Route the response valid to the initiator at the FIFO head.
    always_comb begin
        mn_icb_rsp_vld = {P_ICB_COUNT{1'b0}};
        if (rsp_route_s) begin
            mn_icb_rsp_vld[fifo_head_s] = s_icb_rsp_vld;
        end else begin
            mn_icb_rsp_vld = {P_ICB_COUNT{1'b0}};
        end
    end

endmodule

// File: tb/tb_lnrv_icb_mux.sv
// -----------------------------------------------------------------------------
// tb_lnrv_icb_mux
// Directed bench for lnrv_icb_mux with N=2, OTS=4. Inputs change 1ns after the
// rising edge, outputs are checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_lnrv_icb_mux;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int N   = 2;
    localparam int OTS = 4;
    localparam int SW  = DW / 8;

    logic              clk;
    logic              reset_n;
    logic [N-1:0]      mn_icb_cmd_vld;
    logic [N-1:0]      mn_icb_cmd_rdy;
    logic [N-1:0]      mn_icb_cmd_write;
    logic [N*AW-1:0]   mn_icb_cmd_addr;
    logic [N*DW-1:0]   mn_icb_cmd_wdata;
    logic [N*SW-1:0]   mn_icb_cmd_wstrb;
    logic [N-1:0]      mn_icb_rsp_vld;
    logic [N-1:0]      mn_icb_rsp_rdy;
    logic [N*DW-1:0]   mn_icb_rsp_rdata;
    logic [N-1:0]      mn_icb_rsp_err;
    logic              s_icb_cmd_vld;
    logic              s_icb_cmd_rdy;
    logic              s_icb_cmd_write;
    logic [AW-1:0]     s_icb_cmd_addr;
    logic [DW-1:0]     s_icb_cmd_wdata;
    logic [SW-1:0]     s_icb_cmd_wstrb;
    logic              s_icb_rsp_vld;
    logic              s_icb_rsp_rdy;
    logic [DW-1:0]     s_icb_rsp_rdata;
    logic              s_icb_rsp_err;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];
    int exp_g[2];

    lnrv_icb_mux #(
        .P_ADDR_WIDTH (AW),
        .P_DATA_WIDTH (DW),
        .P_ICB_COUNT  (N),
        .P_OTS_COUNT  (OTS)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .mn_icb_cmd_vld   (mn_icb_cmd_vld),
        .mn_icb_cmd_rdy   (mn_icb_cmd_rdy),
        .mn_icb_cmd_write (mn_icb_cmd_write),
        .mn_icb_cmd_addr  (mn_icb_cmd_addr),
        .mn_icb_cmd_wdata (mn_icb_cmd_wdata),
        .mn_icb_cmd_wstrb (mn_icb_cmd_wstrb),
        .mn_icb_rsp_vld   (mn_icb_rsp_vld),
        .mn_icb_rsp_rdy   (mn_icb_rsp_rdy),
        .mn_icb_rsp_rdata (mn_icb_rsp_rdata),
        .mn_icb_rsp_err   (mn_icb_rsp_err),
        .s_icb_cmd_vld    (s_icb_cmd_vld),
        .s_icb_cmd_rdy    (s_icb_cmd_rdy),
        .s_icb_cmd_write  (s_icb_cmd_write),
        .s_icb_cmd_addr   (s_icb_cmd_addr),
        .s_icb_cmd_wdata  (s_icb_cmd_wdata),
        .s_icb_cmd_wstrb  (s_icb_cmd_wstrb),
        .s_icb_rsp_vld    (s_icb_rsp_vld),
        .s_icb_rsp_rdy    (s_icb_rsp_rdy),
        .s_icb_rsp_rdata  (s_icb_rsp_rdata),
        .s_icb_rsp_err    (s_icb_rsp_err)
    );

    // 10ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle();
        mn_icb_cmd_vld   = 2'b00;
        mn_icb_cmd_write = 2'b00;
        mn_icb_cmd_addr  = 64'h0;
        mn_icb_cmd_wdata = 64'h0;
        mn_icb_cmd_wstrb = 8'h00;
        mn_icb_rsp_rdy   = 2'b00;
        s_icb_cmd_rdy    = 1'b0;
        s_icb_rsp_vld    = 1'b0;
        s_icb_rsp_rdata  = 32'h0;
        s_icb_rsp_err    = 1'b0;
    endtask

    // Return one response per queued owner, all initiators ready.
    task automatic drain_all();
        int e;
        s_icb_rsp_vld   = 1'b1;
        s_icb_rsp_rdata = 32'h1234;
        s_icb_rsp_err   = 1'b1;
        mn_icb_rsp_rdy  = 2'b11;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            smp();
            chk("drain_rsp_vld", 64'(mn_icb_rsp_vld), 64'(2'b01 << e));
            chk("drain_s_rsp_rdy", 64'(s_icb_rsp_rdy), 64'h1);
            chk("drain_rdata_bcast", 64'(mn_icb_rsp_rdata[63:32]), 64'h1234);
            chk("drain_err_bcast", 64'(mn_icb_rsp_err), 64'h3);
            adv();
        end
        smp();
        chk("drain_empty_rdy", 64'(s_icb_rsp_rdy), 64'h0);
        adv();
        idle();
    endtask

    initial begin
        // ---------------- reset state ----------------
        idle();
        reset_n          = 1'b0;
        mn_icb_cmd_vld   = 2'b11;
        s_icb_cmd_rdy    = 1'b1;
        s_icb_rsp_vld    = 1'b1;
        mn_icb_rsp_rdy   = 2'b11;
        smp();
        chk("rst_s_cmd_vld", 64'(s_icb_cmd_vld), 64'h0);
        chk("rst_cmd_rdy", 64'(mn_icb_cmd_rdy), 64'h0);
        chk("rst_rsp_vld", 64'(mn_icb_rsp_vld), 64'h0);
        chk("rst_s_rsp_rdy", 64'(s_icb_rsp_rdy), 64'h0);
        adv();
        adv();
        reset_n = 1'b1;
        smp();
        chk("en_q_s_cmd_vld", 64'(s_icb_cmd_vld), 64'h0);
        chk("en_q_cmd_rdy", 64'(mn_icb_cmd_rdy), 64'h0);
        chk("en_q_s_rsp_rdy", 64'(s_icb_rsp_rdy), 64'h0);
        adv();
        idle();

        // ---------------- 1: single read from init0 ----------------
        mn_icb_cmd_vld             = 2'b01;
        mn_icb_cmd_addr[31:0]      = 32'h0002_0000;
        s_icb_cmd_rdy              = 1'b1;
        smp();
        chk("t1_s_cmd_vld", 64'(s_icb_cmd_vld), 64'h1);
        chk("t1_s_cmd_addr", 64'(s_icb_cmd_addr), 64'h2_0000);
        chk("t1_cmd_rdy", 64'(mn_icb_cmd_rdy), 64'h1);
        chk("t1_s_cmd_write", 64'(s_icb_cmd_write), 64'h0);
        adv();
        idle();
        s_icb_rsp_vld   = 1'b1;
        s_icb_rsp_rdata = 32'h55;
        mn_icb_rsp_rdy  = 2'b11;
        smp();
        chk("t1_rsp_vld", 64'(mn_icb_rsp_vld), 64'h1);
        chk("t1_rsp_rdata", 64'(mn_icb_rsp_rdata[31:0]), 64'h55);
        chk("t1_s_rsp_rdy", 64'(s_icb_rsp_rdy), 64'h1);
        adv();
        smp();
        chk("t1_spurious_vld", 64'(mn_icb_rsp_vld), 64'h0);
        chk("t1_spurious_rdy", 64'(s_icb_rsp_rdy), 64'h0);
        adv();
        idle();

        // ---------------- 2: both initiators requesting ----------------
`ifdef LNRV_ICB_MUX_RR_EN
        // init0 was last granted in step 1, so the search starts at init1.
        exp_g[0] = 1;
        exp_g[1] = 0;
`else
        exp_g[0] = 0;
        exp_g[1] = 0;
`endif
        mn_icb_cmd_vld   = 2'b11;
        mn_icb_cmd_write = 2'b11;
        mn_icb_cmd_addr  = {32'h0000_0200, 32'h0000_0100};
        mn_icb_cmd_wstrb = {4'h3, 4'hF};
        s_icb_cmd_rdy    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            smp();
            chk("t2_cmd_rdy", 64'(mn_icb_cmd_rdy), 64'(2'b01 << exp_g[i]));
            chk("t2_s_cmd_addr", 64'(s_icb_cmd_addr), (exp_g[i] == 1) ? 64'h200 : 64'h100);
            chk("t2_s_cmd_wstrb", 64'(s_icb_cmd_wstrb), (exp_g[i] == 1) ? 64'h3 : 64'hF);
            chk("t2_s_cmd_write", 64'(s_icb_cmd_write), 64'h1);
            exp_q.push_back(exp_g[i]);
            adv();
        end
        idle();
        drain_all();

        // ---------------- 3: lock while target stalls ----------------
        mn_icb_cmd_vld        = 2'b10;
        mn_icb_cmd_addr[63:32] = 32'h0000_B000;
        s_icb_cmd_rdy         = 1'b0;
        smp();
        chk("t3_s_cmd_vld", 64'(s_icb_cmd_vld), 64'h1);
        chk("t3_addr_c1", 64'(s_icb_cmd_addr), 64'hB000);
        chk("t3_rdy_c1", 64'(mn_icb_cmd_rdy), 64'h0);
        adv();
        mn_icb_cmd_vld        = 2'b11;
        mn_icb_cmd_addr[31:0] = 32'h0000_A000;
        for (int i = 0; i < 2; i++) begin
            smp();
            chk("t3_addr_held", 64'(s_icb_cmd_addr), 64'hB000);
            chk("t3_rdy_held", 64'(mn_icb_cmd_rdy), 64'h0);
            adv();
        end
        s_icb_cmd_rdy = 1'b1;
        smp();
        chk("t3_hsk_rdy", 64'(mn_icb_cmd_rdy), 64'h2);
        chk("t3_hsk_addr", 64'(s_icb_cmd_addr), 64'hB000);
        adv();
        smp();
        chk("t3_next_rdy", 64'(mn_icb_cmd_rdy), 64'h1);
        chk("t3_next_addr", 64'(s_icb_cmd_addr), 64'hA000);
        adv();
        idle();

        // ---------------- 5: in-order routing with a stalled initiator ----------------
        // Outstanding owners are now 1,0; add another for init1.
        mn_icb_cmd_vld = 2'b10;
        s_icb_cmd_rdy  = 1'b1;
        smp();
        chk("t5_push_rdy", 64'(mn_icb_cmd_rdy), 64'h2);
        adv();
        idle();
        s_icb_rsp_vld  = 1'b1;
        mn_icb_rsp_rdy = 2'b10;
        smp();
        chk("t5_r1_vld", 64'(mn_icb_rsp_vld), 64'h2);
        chk("t5_r1_rdy", 64'(s_icb_rsp_rdy), 64'h1);
        adv();
        for (int i = 0; i < 2; i++) begin
            smp();
            chk("t5_stall_vld", 64'(mn_icb_rsp_vld), 64'h1);
            chk("t5_stall_rdy", 64'(s_icb_rsp_rdy), 64'h0);
            adv();
        end
        mn_icb_rsp_rdy = 2'b11;
        smp();
        chk("t5_r2_vld", 64'(mn_icb_rsp_vld), 64'h1);
        chk("t5_r2_rdy", 64'(s_icb_rsp_rdy), 64'h1);
        adv();
        smp();
        chk("t5_r3_vld", 64'(mn_icb_rsp_vld), 64'h2);
        chk("t5_r3_rdy", 64'(s_icb_rsp_rdy), 64'h1);
        adv();
        smp();
        chk("t5_empty_vld", 64'(mn_icb_rsp_vld), 64'h0);
        chk("t5_empty_rdy", 64'(s_icb_rsp_rdy), 64'h0);
        adv();
        idle();

        // ---------------- 4: outstanding FIFO full ----------------
        mn_icb_cmd_vld        = 2'b01;
        mn_icb_cmd_addr[31:0] = 32'h0000_0300;
        s_icb_cmd_rdy         = 1'b1;
        for (int i = 0; i < OTS; i++) begin
            smp();
            chk("t4_fill_rdy", 64'(mn_icb_cmd_rdy), 64'h1);
            adv();
        end
        smp();
        chk("t4_full_rdy", 64'(mn_icb_cmd_rdy), 64'h0);
        chk("t4_full_s_vld", 64'(s_icb_cmd_vld), 64'h0);
        adv();
        s_icb_rsp_vld  = 1'b1;
        mn_icb_rsp_rdy = 2'b01;
        smp();
        chk("t4_pop_rdy", 64'(s_icb_rsp_rdy), 64'h1);
        chk("t4_no_bypass", 64'(mn_icb_cmd_rdy), 64'h0);
        adv();
        s_icb_rsp_vld = 1'b0;
        smp();
        chk("t4_after_pop_rdy", 64'(mn_icb_cmd_rdy), 64'h1);
        adv();
        smp();
        chk("t4_refull_rdy", 64'(mn_icb_cmd_rdy), 64'h0);

        // ---------------- 6: reset with commands outstanding ----------------
        adv();
        mn_icb_cmd_vld = 2'b11;
        s_icb_cmd_rdy  = 1'b1;
        s_icb_rsp_vld  = 1'b1;
        mn_icb_rsp_rdy = 2'b11;
        reset_n        = 1'b0;
        #1;
        chk("t6_async_s_vld", 64'(s_icb_cmd_vld), 64'h0);
        chk("t6_async_rsp_vld", 64'(mn_icb_rsp_vld), 64'h0);
        smp();
        chk("t6_rst_cmd_rdy", 64'(mn_icb_cmd_rdy), 64'h0);
        chk("t6_rst_s_rsp_rdy", 64'(s_icb_rsp_rdy), 64'h0);
        chk("t6_rst_addr", 64'(s_icb_cmd_addr), 64'h0);
        adv();
        reset_n = 1'b1;
        smp();
        chk("t6_rel_s_vld", 64'(s_icb_cmd_vld), 64'h0);
        chk("t6_rel_cmd_rdy", 64'(mn_icb_cmd_rdy), 64'h0);
        chk("t6_rel_rsp_vld", 64'(mn_icb_rsp_vld), 64'h0);
        chk("t6_rel_s_rsp_rdy", 64'(s_icb_rsp_rdy), 64'h0);
        adv();
        smp();
        chk("t6_en_s_vld", 64'(s_icb_cmd_vld), 64'h1);
        chk("t6_en_rsp_vld", 64'(mn_icb_rsp_vld), 64'h0);
        chk("t6_en_s_rsp_rdy", 64'(s_icb_rsp_rdy), 64'h0);
        adv();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
